load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage between the EX/MEM pipeline register and the word-wide data memory (async read, sync full-word write).
- Adds byte and halfword loads/stores (LB/LBU/LH/LHU/SB/SH) on top of LW/SW, with alignment checking.
- Sub-word stores use a 2-cycle read-modify-write and raise stall to the hazard unit.
- Registers the load result and status toward the MEM/WB register.

Parameters:
- WIDTH, 32, data and address width.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  1  memory request present this cycle
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  input  1  zero-extend loads when 1, sign-extend when 0
- req_addr  input  WIDTH  byte address
- req_wdata  input  WIDTH  store data, right-justified
- stall  output  1  hold upstream stages this cycle
- mem_addr  output  WIDTH  byte address to data memory
- mem_we  output  1  data memory write enable
- mem_wdata  output  WIDTH  full word to data memory
- mem_rdata  input  WIDTH  word read from data memory (combinational)
- rsp_valid  output  1  registered: a request completed last cycle
- rsp_rdata  output  WIDTH  registered load result (0 for stores and errors)
- rsp_err  output  1  registered misalignment/reserved-size flag

Behaviour:
- Little-endian lanes: byte lane n = bits [8n+7:8n], n = addr[1:0]; halfword at addr[1] selects bits [15:0] or [31:16].
- Alignment:
  - half requires addr[0]=0; word requires addr[1:0]=00.
  - size 11 is always an error.
  - An errored request: mem_we=0, no stall, rsp_err=1, rsp_rdata=0.
- FSM states: IDLE, RMW_WR.
- IDLE, mem_addr:
  - mem_addr = req_addr (combinational pass-through).
  - mem_we=0 unless stated otherwise below.
- IDLE, load (valid, no error):
  - Extract the lane from mem_rdata and extend per req_unsigned/size.
  - Next edge: rsp_valid=1, rsp_rdata=result, rsp_err=0.
  - Latency 1 cycle, no stall.
- IDLE, word store:
  - mem_we=1, mem_wdata=req_wdata in the same cycle.
  - Next edge: rsp_valid=1, rsp_rdata=0.
  - No stall.
- IDLE, byte/half store (first RMW cycle):
  - stall=1, mem_we=0.
  - Capture merged word = mem_rdata with the selected lane(s) replaced by req_wdata[7:0] or [15:0].
  - Capture word-aligned address into registers; next state RMW_WR.
  - rsp_valid=0 at the next edge.
- RMW_WR:
  - mem_addr = latched address, mem_we=1, mem_wdata = merged word, stall=0.
  - Request inputs ignored (upstream still presents the held store).
  - Next edge: state IDLE, rsp_valid=1, rsp_rdata=0, rsp_err=0.
- No request in IDLE: rsp_valid=0 at the next edge; rsp_rdata/rsp_err hold their previous values.
- stall is high only in the first RMW cycle. Upstream must hold all req_* stable while stall=1.
- Back-to-back:
  - A load issued the cycle after RMW_WR sees the written data (write commits at the RMW_WR edge).
  - A load right after SW also sees the new data.
- Reset, asserted at any time:
  - State IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Latched address and merged word cleared.
  - mem_we forced 0 immediately; a pending RMW write is abandoned.
- mem_we is never 1 for an errored request or when req_valid=0 in IDLE.

Test Plan:
1. Word path:
   - SW 0xDEADBEEF to 0x20 → mem_we=1 same cycle, stall stays 0, rsp_valid next cycle.
   - LW 0x20 → rsp_rdata=0xDEADBEEF one cycle later.
2. Sub-word loads, word at 0x10 preset to 0x8822F344:
   - LB 0x13 → 0xFFFFFF88.
   - LBU 0x13 → 0x00000088.
   - LH 0x10 → 0xFFFFF344.
   - LHU 0x12 → 0x00008822.
   - All with rsp_err=0.
3. SB 0x000000AB to 0x11 on 0x8822F344:
   - Cycle 0: stall=1, mem_we=0.
   - Cycle 1: mem_we=1, mem_addr=0x10, mem_wdata=0x8822AB44.
   - rsp_valid on the following edge.
   - Then SH 0x0000BEEF to 0x12 → memory word 0xBEEFAB44.
4. Misaligned/reserved:
   - LW 0x22, SH 0x13, size=11 at 0x10 → each gives rsp_err=1, rsp_rdata=0, mem_we never 1, stall never 1.
   - Memory contents unchanged.
5. Hazards: SB 0x5A to 0x10 immediately followed by LBU 0x10 → load returns 0x0000005A with no extra stall beyond the store's single stall cycle.
6. Mid-RMW reset:
   - Drop rst_n during RMW_WR → mem_we falls without waiting for a clock edge; rsp_valid/rsp_rdata/rsp_err=0.
   - After release, state is IDLE and the first LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-access stage: byte/half/word loads and stores against a word-wide
// data memory. Sub-word stores use a two-cycle read-modify-write.
module load_store_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             stall,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);

  typedef enum logic [0:0] {StIdle, StRmwWr} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] merged_q, merged_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  logic             misaligned;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] merged;
  logic             mem_we_c;

  // Alignment / reserved-size check.
  always_comb begin
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Lane extraction and sign/zero extension of load data.
  always_comb begin
    rd_byte   = mem_rdata[{req_addr[1:0], 3'b000} +: 8];
    rd_half   = mem_rdata[{req_addr[1], 4'b0000} +: 16];
    load_data = mem_rdata;
    case (req_size)
      2'b00:   load_data = {{(WIDTH-8){~req_unsigned & rd_byte[7]}}, rd_byte};
      2'b01:   load_data = {{(WIDTH-16){~req_unsigned & rd_half[15]}}, rd_half};
      default: load_data = mem_rdata;
    endcase
  end

  // Merge sub-word store data into the current memory word.
  always_comb begin
    merged = mem_rdata;
    if (req_size == 2'b00) begin
      merged[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
    end else begin
      merged[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
    end
  end

  // Next-state, memory-side outputs and response next values.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    merged_d    = merged_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    stall       = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr    = req_addr;
    mem_wdata   = req_wdata;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (misaligned) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end else if (!req_write) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = load_data;
            rsp_err_d   = 1'b0;
          end else if (req_size == 2'b10) begin
            mem_we_c    = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
          end else begin
            // First RMW cycle: read old word, hold upstream.
            stall    = 1'b1;
            addr_d   = {req_addr[WIDTH-1:2], 2'b00};
            merged_d = merged;
            state_d  = StRmwWr;
          end
        end
      end
      StRmwWr: begin
        mem_addr    = addr_q;
        mem_we_c    = 1'b1;
        mem_wdata   = merged_q;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  // Reset kills a write immediately, without waiting for an edge.
  assign mem_we = mem_we_c & rst_n;

  // State and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      merged_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      merged_q    <= merged_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory and a
// response scoreboard.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, mem_we, rsp_valid, rsp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, rsp_rdata;

  logic [31:0] mem [0:63];
  logic [32:0] sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  load_store_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  // Memory model: async read, sync write.
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop an expected response whenever the DUT presents one.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e[32:1]);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[0]});
      end
    end
  end

  task automatic do_op(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input logic [31:0] exp_wd);
    logic sub;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = d;
    sb_q.push_back({exp_rd, exp_err});
    sub = w && !exp_err && (sz != 2'b10);
    #1;
    chk("stall_c0", {31'd0, stall}, {31'd0, sub});
    chk("mem_we_c0", {31'd0, mem_we}, {31'd0, w && !exp_err && (sz == 2'b10)});
    chk("mem_addr_c0", mem_addr, a);
    if (w && !exp_err && sz == 2'b10) chk("mem_wdata_sw", mem_wdata, exp_wd);
    if (sub) begin
      @(posedge clk); #1;
      chk("rsp_valid_rmw0", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk); #1;
      chk("stall_c1", {31'd0, stall}, 32'd0);
      chk("mem_we_c1", {31'd0, mem_we}, 32'd1);
      chk("mem_addr_c1", mem_addr, {a[31:2], 2'b00});
      chk("mem_wdata_c1", mem_wdata, exp_wd);
    end
    @(posedge clk); #1;
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'h8822F344;
    mem[5] = 32'h11223344;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    #2;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Word path.
    do_op(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 32'hDEADBEEF);
    do_op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0);

    // Sub-word loads on 0x8822F344.
    do_op(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 32'h0);
    do_op(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000088, 1'b0, 32'h0);
    do_op(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFFF344, 1'b0, 32'h0);
    do_op(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h00008822, 1'b0, 32'h0);

    // Idle cycle: rsp_valid drops, data holds.
    @(negedge clk); req_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("idle_rsp_hold", rsp_rdata, 32'h00008822);

    // Sub-word stores.
    do_op(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB, 32'h0, 1'b0, 32'h8822AB44);
    do_op(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF, 32'h0, 1'b0, 32'hBEEFAB44);
    do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hBEEFAB44, 1'b0, 32'h0);
    chk("mem_after_sh", mem[4], 32'hBEEFAB44);

    // Misaligned and reserved size.
    do_op(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'h0, 1'b1, 32'h0);
    do_op(1'b1, 2'b01, 1'b0, 32'h13, 32'h00001234, 32'h0, 1'b1, 32'h0);
    do_op(1'b1, 2'b11, 1'b0, 32'h10, 32'hCAFEF00D, 32'h0, 1'b1, 32'h0);
    chk("mem_unch_10", mem[4], 32'hBEEFAB44);
    chk("mem_unch_20", mem[8], 32'hDEADBEEF);

    // Store then dependent load with no extra stall.
    do_op(1'b1, 2'b00, 1'b0, 32'h10, 32'h0000005A, 32'h0, 1'b0, 32'hBEEFAB5A);
    do_op(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'h0000005A, 1'b0, 32'h0);

    // Reset in the middle of an RMW.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h14; req_wdata = 32'h00000077;
    #1;
    chk("rmwrst_stall", {31'd0, stall}, 32'd1);
    @(negedge clk); #1;
    chk("rmwrst_we_before", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rmwrst_we_after", {31'd0, mem_we}, 32'd0);
    chk("rmwrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rmwrst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rmwrst_rsp_err", {31'd0, rsp_err}, 32'd0);
    sb_q.delete();
    req_valid = 1'b0;
    @(negedge clk);
    chk("rmwrst_mem", mem[5], 32'h11223344);
    rst_n = 1'b1;
    do_op(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h11223344, 1'b0, 32'h0);

    @(negedge clk); req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
